// File: rtl/divisor_select.sv
// divisor_select: synchronised, debounced UP/DN buttons stepping a
// saturating 4-bit divisor select, with optional auto-repeat on hold.
module divisor_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter logic [3:0]  RESET_SEL       = 4'b1111
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_UP,
    input  logic       BTN_DN,
    output logic [3:0] SEL,
    output logic       CHANGED,
    output logic       LIMIT
);

    localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] RPT_LAST = 24'(REPEAT_CYCLES - 1);
    localparam logic        RPT_EN   = (REPEAT_CYCLES != 0);

    // Bit 0 carries the UP button, bit 1 the DN button.
    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [1:0]       db_q, db_d;
    logic [1:0]       db_prev_q, db_prev_d;
    logic [1:0][23:0] cnt_q, cnt_d;
    logic [23:0]      rpt_q, rpt_d;
    logic [3:0]       sel_q, sel_d;
    logic             changed_q, changed_d;
    logic             limit_q, limit_d;

    logic [1:0] rise;
    logic [1:0] req;
    logic       one_held;
    logic       db_edge;
    logic       rpt_fire;

    always_comb begin
        s1_d      = {BTN_DN, BTN_UP};
        s2_d      = s1_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        db_prev_d = db_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 24'd1;
            end
        end
    end

    // Repeat only ticks while a single button stays held with no db edge.
    always_comb begin
        rise     = db_q & ~db_prev_q;
        db_edge  = |(db_q ^ db_prev_q);
        one_held = db_q[0] ^ db_q[1];
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (RPT_EN && one_held && !db_edge) begin
            if (rpt_q == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_q + 24'd1;
            end
        end
        req = rise | (rpt_fire ? db_q : 2'b00);
    end

    always_comb begin
        sel_d     = sel_q;
        changed_d = 1'b0;
        limit_d   = 1'b0;
        case (req)
            2'b01: begin
                if (sel_q == 4'hF) begin
                    limit_d = 1'b1;
                end else begin
                    sel_d     = sel_q + 4'd1;
                    changed_d = 1'b1;
                end
            end
            2'b10: begin
                if (sel_q == 4'h0) begin
                    limit_d = 1'b1;
                end else begin
                    sel_d     = sel_q - 4'd1;
                    changed_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
            rpt_q     <= '0;
            sel_q     <= RESET_SEL;
            changed_q <= 1'b0;
            limit_q   <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
            limit_q   <= limit_d;
        end
    end

    assign SEL     = sel_q;
    assign CHANGED = changed_q;
    assign LIMIT   = limit_q;

endmodule

// File: tb/tb_divisor_select.sv
// Bench for divisor_select: directed button scenarios plus a random run
// checked against a sample-window / hold-time model of the button path.
module tb_divisor_select;

    localparam int DB = 4;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up0 = 1'b0;
    logic       dn0 = 1'b0;
    logic       up1 = 1'b0;
    logic       dn1 = 1'b0;
    logic [3:0] sel0;
    logic [3:0] sel1;
    logic       chg0, lim0, chg1, lim1;

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk = ~clk;

    divisor_select #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (0),
        .RESET_SEL      (4'b1111)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .BTN_UP (up0),
        .BTN_DN (dn0),
        .SEL    (sel0),
        .CHANGED(chg0),
        .LIMIT  (lim0)
    );

    divisor_select #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP),
        .RESET_SEL      (4'b1111)
    ) dut_rpt (
        .CLK    (clk),
        .RST    (rst),
        .BTN_UP (up1),
        .BTN_DN (dn1),
        .SEL    (sel1),
        .CHANGED(chg1),
        .LIMIT  (lim1)
    );

    // Model: a level is accepted once the last DB synchronised samples all
    // disagree with it; repeats land every RP-th cycle of a steady single hold.
    logic          m_d1  [2][2];
    logic          m_d2  [2][2];
    logic [DB-1:0] m_win [2][2];
    int            m_wn  [2][2];
    logic          m_db  [2][2];
    logic          m_pv  [2][2];
    int            m_run [2];
    logic [3:0]    m_sel [2];
    logic          m_chg [2];
    logic          m_lim [2];

    always @(posedge clk) begin : model
        logic b [2][2];
        logic held, stable, rep, ru, rd, s2;
        int   rp;
        b[0][0] = up0;
        b[0][1] = dn0;
        b[1][0] = up1;
        b[1][1] = dn1;
        for (int i = 0; i < 2; i++) begin
            rp = (i == 1) ? RP : 0;
            if (rst) begin
                m_sel[i] = 4'hF;
                m_chg[i] = 1'b0;
                m_lim[i] = 1'b0;
                m_run[i] = 0;
                for (int k = 0; k < 2; k++) begin
                    m_d1[i][k]  = 1'b0;
                    m_d2[i][k]  = 1'b0;
                    m_win[i][k] = '0;
                    m_wn[i][k]  = 0;
                    m_db[i][k]  = 1'b0;
                    m_pv[i][k]  = 1'b0;
                end
            end else begin
                held   = m_db[i][0] ^ m_db[i][1];
                stable = held && (m_db[i][0] == m_pv[i][0])
                              && (m_db[i][1] == m_pv[i][1]);
                m_run[i] = stable ? m_run[i] + 1 : 0;
                rep = 1'b0;
                if (rp > 0 && stable) rep = ((m_run[i] % rp) == 0);
                ru = (m_db[i][0] && !m_pv[i][0]) || (rep && m_db[i][0]);
                rd = (m_db[i][1] && !m_pv[i][1]) || (rep && m_db[i][1]);
                m_chg[i] = 1'b0;
                m_lim[i] = 1'b0;
                if (ru && !rd) begin
                    if (m_sel[i] == 4'hF) m_lim[i] = 1'b1;
                    else begin
                        m_sel[i] = m_sel[i] + 4'd1;
                        m_chg[i] = 1'b1;
                    end
                end else if (rd && !ru) begin
                    if (m_sel[i] == 4'h0) m_lim[i] = 1'b1;
                    else begin
                        m_sel[i] = m_sel[i] - 4'd1;
                        m_chg[i] = 1'b1;
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    m_pv[i][k]  = m_db[i][k];
                    s2          = m_d2[i][k];
                    m_win[i][k] = {m_win[i][k][DB-2:0], s2};
                    if (m_wn[i][k] < DB) m_wn[i][k]++;
                    if (m_wn[i][k] == DB && m_win[i][k] == {DB{~m_db[i][k]}})
                        m_db[i][k] = ~m_db[i][k];
                    m_d2[i][k] = m_d1[i][k];
                    m_d1[i][k] = b[i][k];
                end
            end
        end
    end

    task automatic press(input int inst, input bit is_up,
                         input int hold, input int gap);
        if (inst == 0) begin
            if (is_up) up0 = 1'b1; else dn0 = 1'b1;
        end else begin
            if (is_up) up1 = 1'b1; else dn1 = 1'b1;
        end
        repeat (hold) @(negedge clk);
        up0 = 1'b0; dn0 = 1'b0; up1 = 1'b0; dn1 = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (sel0 !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_sel0: got %h expected f", sel0);
        end
        n_checks++;
        if (chg0 !== 1'b0 || lim0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses0: chg=%b lim=%b expected 0 0", chg0, lim0);
        end
        n_checks++;
        if (sel1 !== 4'hF || chg1 !== 1'b0 || lim1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut1: sel=%h chg=%b lim=%b expected f 0 0",
                     sel1, chg1, lim1);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (sel0 !== 4'hF || chg0 !== 1'b0 || lim0 !== 1'b0 ||
                sel1 !== 4'hF || chg1 !== 1'b0 || lim1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: sel0=%h chg0=%b lim0=%b sel1=%h chg1=%b lim1=%b expected f00 f00",
                         c, sel0, chg0, lim0, sel1, chg1, lim1);
            end
        end
    endtask

    task automatic test_dn_press();
        dn0 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            n_checks++;
            if (sel0 !== ((k >= 6) ? 4'd14 : 4'd15)) begin
                n_fail++;
                $display("FAIL dn_press_sel edge%0d: got %0d expected %0d",
                         k, sel0, (k >= 6) ? 14 : 15);
            end
            n_checks++;
            if (chg0 !== (k == 6) || lim0 !== 1'b0) begin
                n_fail++;
                $display("FAIL dn_press_pulse edge%0d: chg=%b lim=%b expected %b 0",
                         k, chg0, lim0, (k == 6));
            end
            if (k == 9) dn0 = 1'b0;
        end
    endtask

    task automatic test_saturation();
        int nl;
        int nc;
        repeat (14) press(0, 1'b0, 6, 8);
        n_checks++;
        if (sel0 !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_reach_zero: got %0d expected 0", sel0);
        end
        nl = 0; nc = 0;
        dn0 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lim0) nl++;
            if (chg0) nc++;
            if (k == 5) dn0 = 1'b0;
        end
        n_checks++;
        if (nl != 1 || nc != 0 || sel0 !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_low: limits=%0d changes=%0d sel=%0d expected 1 0 0",
                     nl, nc, sel0);
        end
        repeat (15) press(0, 1'b1, 6, 8);
        n_checks++;
        if (sel0 !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_reach_top: got %0d expected 15", sel0);
        end
        nl = 0; nc = 0;
        up0 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lim0) nl++;
            if (chg0) nc++;
            if (k == 5) up0 = 1'b0;
        end
        n_checks++;
        if (nl != 1 || nc != 0 || sel0 !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_high: limits=%0d changes=%0d sel=%0d expected 1 0 15",
                     nl, nc, sel0);
        end
    endtask

    task automatic test_bounce();
        for (int j = 0; j < 16; j++) begin
            up0 = (j < 8) ? ((j / 2) % 2 == 0) : 1'b0;
            @(negedge clk);
            n_checks++;
            if (sel0 !== 4'd15 || chg0 !== 1'b0 || lim0 !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce c%0d: sel=%0d chg=%b lim=%b expected 15 0 0",
                         j, sel0, chg0, lim0);
            end
        end
    endtask

    task automatic test_simultaneous();
        up0 = 1'b1;
        dn0 = 1'b1;
        for (int j = 0; j < 36; j++) begin
            if (j == 12) dn0 = 1'b0;
            if (j == 24) up0 = 1'b0;
            @(negedge clk);
            n_checks++;
            if (sel0 !== 4'd15 || chg0 !== 1'b0 || lim0 !== 1'b0) begin
                n_fail++;
                $display("FAIL simultaneous c%0d: sel=%0d chg=%b lim=%b expected 15 0 0",
                         j, sel0, chg0, lim0);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int         w;
        bit         found;
        logic [3:0] exp_sel;
        repeat (13) press(1, 1'b0, 5, 8);
        n_checks++;
        if (sel1 !== 4'd2) begin
            n_fail++;
            $display("FAIL rpt_setup: got %0d expected 2", sel1);
        end
        w = 0;
        found = 1'b0;
        up1 = 1'b1;
        while (!found && w < 20) begin
            @(negedge clk);
            if (chg1 === 1'b1) found = 1'b1;
            else w++;
        end
        n_checks++;
        if (!found || w != 6) begin
            n_fail++;
            $display("FAIL rpt_first_step: found=%b edge=%0d expected 1 6", found, w);
        end
        n_checks++;
        if (sel1 !== 4'd3) begin
            n_fail++;
            $display("FAIL rpt_first_sel: got %0d expected 3", sel1);
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            exp_sel = 4'd3 + 4'(c / 8);
            n_checks++;
            if (sel1 !== exp_sel || chg1 !== (c % 8 == 0) || lim1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rpt_hold +%0d: sel=%0d chg=%b lim=%b expected %0d %b 0",
                         c, sel1, chg1, lim1, exp_sel, (c % 8 == 0));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (sel1 !== 4'hF || chg1 !== 1'b0 || lim1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rpt_reset: sel=%0d chg=%b lim=%b expected 15 0 0",
                     sel1, chg1, lim1);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_checks++;
            if (sel1 !== 4'hF || chg1 !== 1'b0 || lim1 !== (k == 7)) begin
                n_fail++;
                $display("FAIL rpt_after_reset k%0d: sel=%0d chg=%b lim=%b expected 15 0 %b",
                         k, sel1, chg1, lim1, (k == 7));
            end
        end
        up1 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        int   rem [2][2];
        logic lvl;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++) rem[i][k] = 0;
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if (rem[i][k] == 0) begin
                        lvl = ($urandom_range(0, 2) == 0);
                        rem[i][k] = $urandom_range(1, 20);
                        case ({i[0], k[0]})
                            2'b00:   up0 = lvl;
                            2'b01:   dn0 = lvl;
                            2'b10:   up1 = lvl;
                            default: dn1 = lvl;
                        endcase
                    end
                    rem[i][k]--;
                end
            end
            @(negedge clk);
            n_checks++;
            if (sel0 !== m_sel[0] || chg0 !== m_chg[0] || lim0 !== m_lim[0]) begin
                n_fail++;
                $display("FAIL rand_dut0 c%0d: sel=%0d chg=%b lim=%b expected %0d %b %b",
                         c, sel0, chg0, lim0, m_sel[0], m_chg[0], m_lim[0]);
            end
            n_checks++;
            if (sel1 !== m_sel[1] || chg1 !== m_chg[1] || lim1 !== m_lim[1]) begin
                n_fail++;
                $display("FAIL rand_dut1 c%0d: sel=%0d chg=%b lim=%b expected %0d %b %b",
                         c, sel1, chg1, lim1, m_sel[1], m_chg[1], m_lim[1]);
            end
            n_checks++;
            if ((chg0 && lim0) || (chg1 && lim1)) begin
                n_fail++;
                $display("FAIL rand_exclusive c%0d: chg0=%b lim0=%b chg1=%b lim1=%b expected never both",
                         c, chg0, lim0, chg1, lim1);
            end
        end
        rst = 1'b0;
        up0 = 1'b0; dn0 = 1'b0; up1 = 1'b0; dn1 = 1'b0;
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_dn_press();
        test_saturation();
        test_bounce();
        test_simultaneous();
        test_auto_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
